// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the device over the shared open-drain psClk/psData
// pins. Pins are modelled as sense inputs plus pull-low enables; the top level
// builds the actual tri-states.
//
// Handshake: tx_start is a single-cycle request that is accepted only when the
// FSM is in IDLE (tx_busy=0 and no done/error pulse in that cycle). tx_data is
// sampled in the accepting cycle. Every request that is accepted ends with
// exactly one single-cycle tx_done or tx_error pulse. tx_busy is low in the
// cycle that carries that pulse. A request that arrives in any other cycle is
// dropped and is not queued.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       psClk_in,
  input  logic       psData_in,
  output logic       psClk_oe,
  output logic       psData_oe,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // Last count value of each timed phase. The counter restarts at 0 on entry
  // to a phase, so "cnt == X_LAST" marks the final cycle of that phase.
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       bit_idx;
  logic [3:0]       bit_next;
  logic             load;
  logic [7:0]       data_q;
  logic             par_q;

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             clk_s;
  logic             data_s;
  logic             fall;

  logic             clk_oe_d;
  logic             data_oe_d;
  logic             busy_d;
  logic             done_d;
  logic             err_d;
  logic             frame_oe;

  assign state_dbg = state;

  // Two-flop synchronizers on both pins, plus a registered copy of the synced
  // clock for falling-edge detection. They reset to 1, the idle bus level.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], psClk_in};
      data_sync <= {data_sync[0], psData_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;

  // State register, together with the shared cycle counter, the bit index,
  // and the byte and odd parity captured when a request is accepted.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      if (load) begin
        data_q <= tx_data;
        par_q  <= ~^tx_data;
      end
    end
  end

  // Next-state logic. A qualifying event (fall, ACK fall, or bus release)
  // always takes priority over the timeout in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    bit_next   = bit_idx;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (tx_start) begin
          state_next = S_INHIBIT;
          load       = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_next = S_REQ;
          cnt_next   = '0;
        end
      end
      S_REQ: begin
        state_next = S_SEND;
        cnt_next   = '0;
        bit_next   = 4'd0;
      end
      S_SEND: begin
        if (fall) begin
          cnt_next = '0;
          bit_next = bit_idx + 4'd1;
          if (bit_idx == 4'd9) begin
            state_next = S_ACK;
          end
        end else if (cnt == TMO_LAST) begin
          state_next = S_ERROR;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_next   = '0;
          state_next = data_s ? S_ERROR : S_RELEASE;
        end else if (cnt == TMO_LAST) begin
          state_next = S_ERROR;
        end
      end
      S_RELEASE: begin
        if (clk_s && data_s) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else if (cnt == TMO_LAST) begin
          state_next = S_ERROR;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      S_ERROR: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic. Next values are computed from the state being entered so
  // that every pin enable and status flag comes straight from a flop.
  always_comb begin
    if (bit_idx < 4'd8) begin
      frame_oe = ~data_q[bit_idx[2:0]];
    end else if (bit_idx == 4'd8) begin
      frame_oe = ~par_q;
    end else begin
      frame_oe = 1'b0;
    end

    clk_oe_d  = (state_next == S_INHIBIT) || (state_next == S_REQ);
    busy_d    = !((state_next == S_IDLE) || (state_next == S_DONE) ||
                  (state_next == S_ERROR));
    done_d    = (state_next == S_DONE);
    err_d     = (state_next == S_ERROR);

    data_oe_d = psData_oe;
    if ((state == S_SEND) && fall) begin
      data_oe_d = frame_oe;
    end
    case (state_next)
      S_IDLE, S_DONE, S_ERROR: data_oe_d = 1'b0;
      // The start bit goes onto the bus in the last inhibit cycle.
      S_INHIBIT:               data_oe_d = (cnt_next == INH_LAST);
      S_REQ:                   data_oe_d = 1'b1;
      default:                 data_oe_d = data_oe_d;
    endcase
  end

  // Output registers. Reset releases both lines at once.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      psClk_oe  <= 1'b0;
      psData_oe <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      psClk_oe  <= clk_oe_d;
      psData_oe <= data_oe_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
      tx_error  <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx. It includes a behavioural PS/2 device on an open-drain
// bus model and a frame model that is computed from the byte value.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 200;

  logic       Clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       psClk_in, psData_in, psClk_oe, psData_oe;
  logic [2:0] state_dbg;
  logic       dev_clk, dev_data;

  // Wired-AND bus: a line is high only if neither side pulls it low.
  assign psClk_in  = dev_clk & ~psClk_oe;
  assign psData_in = dev_data & ~psData_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(17)) dut (
    .Clk(Clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .psClk_in(psClk_in), .psData_in(psData_in),
    .psClk_oe(psClk_oe), .psData_oe(psData_oe), .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end before 50000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] last_bits;
  int          last_fall_cyc = 0;
  int          base_done = 0, base_err = 0;

  // ---------------- bus monitor (samples on negedge) ----------------
  logic done_prev = 1'b0, err_prev = 1'b0, clk_oe_prev = 1'b0, data_oe_prev = 1'b0;
  int   done_pulses = 0, err_pulses = 0, err_cyc = 0;
  int   clk_run = 0, last_clk_run = 0, clk_rises = 0, clk_rise_cyc = 0, data_rise_cyc = 0;
  logic pulse_bad = 1'b0, busy_overlap = 1'b0;

  always @(negedge Clk) begin
    done_prev    <= tx_done;
    err_prev     <= tx_error;
    clk_oe_prev  <= psClk_oe;
    data_oe_prev <= psData_oe;
    if (tx_done && !done_prev) done_pulses <= done_pulses + 1;
    if (tx_error && !err_prev) begin
      err_pulses <= err_pulses + 1;
      err_cyc    <= cyc;
    end
    if ((tx_done && done_prev) || (tx_error && err_prev) || (tx_done && tx_error)) pulse_bad <= 1'b1;
    if ((tx_done || tx_error) && tx_busy) busy_overlap <= 1'b1;
    if (psClk_oe) clk_run <= clk_run + 1;
    else if (clk_run != 0) begin
      last_clk_run <= clk_run;
      clk_run      <= 0;
    end
    if (psClk_oe && !clk_oe_prev) begin
      clk_rises    <= clk_rises + 1;
      clk_rise_cyc <= cyc;
    end
    if (psData_oe && !data_oe_prev && psClk_oe) data_rise_cyc <= cyc;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int          ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  // Device: waits for request-to-send, then generates n_clk clocks (40-cycle
  // period). Start is read before the first clock, later bits on rising edges.
  task automatic device_frame(input int n_clk, input bit ack, output logic [10:0] bits);
    int t;
    bits = '0;
    t    = 0;
    while (psClk_in !== 1'b0 && t < 200) begin step(); t++; end
    while (!(psClk_in === 1'b1 && psData_in === 1'b0) && t < 400) begin step(); t++; end
    check("rts_seen", 32'(t < 400), 32'd1);
    if (t >= 400) return;
    repeat (10) step();
    bits[0] = psData_in;
    for (int i = 1; i <= n_clk; i++) begin
      if (i == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (10) step();
      end
      dev_clk       = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) step();
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = psData_in;
      repeat (20) step();
    end
    if (n_clk == 11) begin
      repeat (5) step();
      dev_data = 1'b1;
    end
  endtask

  task automatic start_tx(input logic [7:0] b, input string tag);
    tx_data  = b;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check({tag, "_clk_oe_after_start"}, 32'(psClk_oe), 32'd1);
    check({tag, "_busy_after_start"}, 32'(tx_busy), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] b, input int n_clk, input bit ack, input string tag);
    logic [10:0] bits, exp, mask;
    base_done = done_pulses;
    base_err  = err_pulses;
    exp_q.push_back(model_frame(b));
    start_tx(b, tag);
    device_frame(n_clk, ack, bits);
    last_bits = bits;
    exp  = exp_q.pop_front();
    mask = (n_clk >= 10) ? 11'h7FF : 11'((1 << (n_clk + 1)) - 1);
    check({tag, "_frame"}, 32'(bits & mask), 32'(exp & mask));
  endtask

  task automatic expect_outcome(input int exp_done, input int exp_err, input string tag);
    int t;
    t = 0;
    while (((done_pulses - base_done) + (err_pulses - base_err)) < exp_done + exp_err && t < 400) begin
      step();
      t++;
    end
    check({tag, "_end_seen"}, 32'(t < 400), 32'd1);
    repeat (5) step();
    check({tag, "_done_pulses"}, 32'(done_pulses - base_done), 32'(exp_done));
    check({tag, "_err_pulses"}, 32'(err_pulses - base_err), 32'(exp_err));
    check({tag, "_pulse_shape"}, 32'(pulse_bad), 32'd0);
    check({tag, "_busy_low_at_pulse"}, 32'(busy_overlap), 32'd0);
    check({tag, "_lines_released"}, 32'({psClk_oe, psData_oe}), 32'd0);
    check({tag, "_busy_end"}, 32'(tx_busy), 32'd0);
    check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
    check({tag, "_clk_oe_len"}, 32'(last_clk_run), 32'(INH + 1));
    check({tag, "_start_bit_lead"}, 32'(data_rise_cyc - clk_rise_cyc), 32'(INH - 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b;
    int         rises0, t;
    logic [7:0] par_bytes[3];
    logic       par_exp[3];

    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #2 reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_clk_oe", 32'(psClk_oe), 32'd0);
    check("rst_data_oe", 32'(psData_oe), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    repeat (5) step();
    check("idle_state", 32'(state_dbg), 32'd0);

    // Nominal 0xF4: exact device-sampled frame from the test plan.
    run_frame(8'hF4, 11, 1'b1, "f4");
    check("f4_bits_exact", 32'(last_bits), 32'(11'b1_0_11110100_0));
    expect_outcome(1, 0, "f4");

    // Parity corner bytes.
    par_bytes[0] = 8'h00; par_exp[0] = 1'b1;
    par_bytes[1] = 8'hFF; par_exp[1] = 1'b1;
    par_bytes[2] = 8'h01; par_exp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_frame(par_bytes[i], 11, 1'b1, $sformatf("par%0d", i));
      check($sformatf("par%0d_parity", i), 32'(last_bits[9]), 32'(par_exp[i]));
      expect_outcome(1, 0, $sformatf("par%0d", i));
    end

    // Random bytes.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      run_frame(b, 11, 1'b1, $sformatf("rnd%0d", i));
      expect_outcome(1, 0, $sformatf("rnd%0d", i));
    end

    // Missing ACK.
    b = 8'($urandom_range(0, 255));
    run_frame(b, 11, 1'b0, "noack");
    expect_outcome(0, 1, "noack");

    // Device stops after 4 clocks. The transmitter sees a pin edge 3 cycles
    // late (2 sync flops + edge register), so the error pulse lands
    // TIMEOUT_CYCLES after that detected fall.
    b = 8'($urandom_range(0, 255));
    run_frame(b, 4, 1'b1, "tmo");
    expect_outcome(0, 1, "tmo");
    check("tmo_latency", 32'(err_cyc - last_fall_cyc), 32'(TMO + 3));

    // tx_start of 0xAA while 0xED is in flight is dropped.
    rises0 = clk_rises;
    fork
      run_frame(8'hED, 11, 1'b1, "busy");
      begin
        repeat (150) step();
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
      end
    join
    expect_outcome(1, 0, "busy");
    repeat (200) step();
    check("busy_single_frame", 32'(clk_rises - rises0), 32'd1);

    // tx_start in the tx_done cycle is dropped.
    fork
      run_frame(8'h01, 11, 1'b1, "donecyc");
      begin
        t = 0;
        while (tx_done !== 1'b1 && t < 3000) begin step(); t++; end
        check("donecyc_pulse_seen", 32'(t < 3000), 32'd1);
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
      end
    join
    rises0 = clk_rises;
    expect_outcome(1, 0, "donecyc");
    repeat (100) step();
    check("donecyc_no_new_frame", 32'(clk_rises - rises0), 32'd0);

    // Reset in the middle of the frame, while bit 5 (forced 0) is driven.
    b = 8'($urandom_range(0, 255)) & 8'hDF;
    run_frame(b, 6, 1'b1, "rst");
    check("rst_bit5_driven", 32'(psData_oe), 32'd1);
    check("rst_busy_before", 32'(tx_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_lines", 32'({psClk_oe, psData_oe}), 32'd0);
    check("rst_async_busy", 32'(tx_busy), 32'd0);
    check("rst_async_state", 32'(state_dbg), 32'd0);
    step();
    reset = 1'b0;
    repeat (50) step();
    check("rst_no_done", 32'(done_pulses - base_done), 32'd0);
    check("rst_no_error", 32'(err_pulses - base_err), 32'd0);
    run_frame(8'hFF, 11, 1'b1, "after_rst");
    expect_outcome(1, 0, "after_rst");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
